wb_commit: RTL and testbench

Writeback commit buffer for the dual-issue core. Accepts up to two completed results per cycle from the execution ways, buffers them in program order in a shared FIFO, and drains up to two writes per cycle onto the RegFile write ports. It is the stage directly upstream of the RegFile write side. It also resolves same-destination conflicts between the two ports so that the younger result always wins.

---
 rtl/wb_commit_if.sv | 41 ++++
 rtl/wb_commit.sv | 69 ++++++
 tb/tb_wb_commit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_if.sv
// Writeback bus between the execution ways, the commit buffer and the RegFile write ports.
// The master side is the producer/RegFile environment; the slave side is the commit buffer.
interface wb_commit_if #(
   parameter int DEPTH = 4
);
   logic                       way0_wbValid_i;
   logic                       way0_rdWriteEnable_i;
   logic [4:0]                 way0_rdAddr_i;
   logic [63:0]                way0_rdData_i;
   logic                       way1_wbValid_i;
   logic                       way1_rdWriteEnable_i;
   logic [4:0]                 way1_rdAddr_i;
   logic [63:0]                way1_rdData_i;
   logic                       wbReady_o;
   logic                       wbStall_i;
   logic                       way0_rdWriteEnable_o;
   logic [4:0]                 way0_rdAddr_o;
   logic [63:0]                way0_rdData_o;
   logic                       way1_rdWriteEnable_o;
   logic [4:0]                 way1_rdAddr_o;
   logic [63:0]                way1_rdData_o;
   logic [$clog2(DEPTH):0]     wbPending_o;

   modport master (
      output way0_wbValid_i, way0_rdWriteEnable_i, way0_rdAddr_i, way0_rdData_i,
      output way1_wbValid_i, way1_rdWriteEnable_i, way1_rdAddr_i, way1_rdData_i,
      output wbStall_i,
      input  wbReady_o, wbPending_o,
      input  way0_rdWriteEnable_o, way0_rdAddr_o, way0_rdData_o,
      input  way1_rdWriteEnable_o, way1_rdAddr_o, way1_rdData_o
   );

   modport slave (
      input  way0_wbValid_i, way0_rdWriteEnable_i, way0_rdAddr_i, way0_rdData_i,
      input  way1_wbValid_i, way1_rdWriteEnable_i, way1_rdAddr_i, way1_rdData_i,
      input  wbStall_i,
      output wbReady_o, wbPending_o,
      output way0_rdWriteEnable_o, way0_rdAddr_o, way0_rdData_o,
      output way1_rdWriteEnable_o, way1_rdAddr_o, way1_rdData_o
   );
endinterface

// File: rtl/wb_commit.sv
// Dual-issue writeback commit buffer: in-order FIFO taking up to two results and
// draining up to two RegFile writes per cycle, with the younger write winning on equal rd.
module wb_commit #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   wb_commit_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [68:0]   entryMem [DEPTH];
   logic [PW-1:0] headReg, tailReg;
   logic [CW-1:0] countReg;

   logic          store0, store1, accept, push0, push1;
   logic          present0, present1;
   logic [PW-1:0] headNext1, tailNext1, wr1Idx;
   logic [1:0]    pushCnt, popCnt;
   logic [68:0]   entry0, entry1;

   assign store0 = bus.way0_wbValid_i & bus.way0_rdWriteEnable_i & (bus.way0_rdAddr_i != 5'd0);
   assign store1 = bus.way1_wbValid_i & bus.way1_rdWriteEnable_i & (bus.way1_rdAddr_i != 5'd0);

   // Readiness depends only on registered occupancy so producers never see a comb loop.
   assign accept = (countReg <= CW'(DEPTH - 2));
   assign push0  = accept & store0;
   assign push1  = accept & store1;

   assign tailNext1 = tailReg + PW'(1);
   assign headNext1 = headReg + PW'(1);
   assign wr1Idx    = push0 ? tailNext1 : tailReg;
   assign pushCnt   = {1'b0, push0} + {1'b0, push1};

   assign present0 = ~bus.wbStall_i & (countReg >= CW'(1));
   assign present1 = ~bus.wbStall_i & (countReg >= CW'(2));
   assign popCnt   = {1'b0, present0} + {1'b0, present1};

   assign entry0 = entryMem[headReg];
   assign entry1 = entryMem[headNext1];

   assign bus.wbReady_o            = accept;
   assign bus.wbPending_o          = countReg;
   assign bus.way0_rdAddr_o        = entry0[68:64];
   assign bus.way0_rdData_o        = entry0[63:0];
   assign bus.way1_rdAddr_o        = entry1[68:64];
   assign bus.way1_rdData_o        = entry1[63:0];
   // The older write is suppressed when the younger one targets the same register.
   assign bus.way0_rdWriteEnable_o = present0 & ~(present1 & (entry0[68:64] == entry1[68:64]));
   assign bus.way1_rdWriteEnable_o = present1;

   always_ff @(posedge clk) begin
      if (push0) entryMem[tailReg] <= {bus.way0_rdAddr_i, bus.way0_rdData_i};
      if (push1) entryMem[wr1Idx]  <= {bus.way1_rdAddr_i, bus.way1_rdData_i};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         headReg  <= '0;
         tailReg  <= '0;
         countReg <= '0;
      end else begin
         headReg  <= headReg + PW'(popCnt);
         tailReg  <= tailReg + PW'(pushCnt);
         countReg <= countReg + CW'(pushCnt) - CW'(popCnt);
      end
   end
endmodule

// File: tb/tb_wb_commit.sv
// Directed and randomised bench for wb_commit: a queue model of the commit buffer is
// checked every cycle, plus hand-computed expectations at key points.
module tb_wb_commit;
   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]  a;
      logic [63:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   vecs = 0;
   int   errs = 0;
   ent_t mq[$];

   wb_commit_if #(.DEPTH(DEPTH)) bus ();

   wb_commit #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Cycle-by-cycle model: a plain queue holding everything stored but not yet written.
   always begin
      @(negedge clk);
      if (!reset_n) begin
         mq.delete();
      end else begin
         automatic int  n   = mq.size();
         automatic bit  rdy = (DEPTH - n) >= 2;
         automatic bit  p0  = !bus.wbStall_i && n >= 1;
         automatic bit  p1  = !bus.wbStall_i && n >= 2;
         automatic bit  ew0 = p0 && !(p1 && mq[0].a == mq[1].a);
         chk("m_ready",   64'(bus.wbReady_o), 64'(rdy));
         chk("m_pending", 64'(bus.wbPending_o), 64'(n));
         chk("m_we0",     64'(bus.way0_rdWriteEnable_o), 64'(ew0));
         chk("m_we1",     64'(bus.way1_rdWriteEnable_o), 64'(p1));
         if (ew0) begin
            chk("m_addr0", 64'(bus.way0_rdAddr_o), 64'(mq[0].a));
            chk("m_data0", bus.way0_rdData_o, mq[0].d);
         end
         if (p1) begin
            chk("m_addr1", 64'(bus.way1_rdAddr_o), 64'(mq[1].a));
            chk("m_data1", bus.way1_rdData_o, mq[1].d);
         end
         if (p1) begin
            void'(mq.pop_front());
            void'(mq.pop_front());
         end else if (p0) begin
            void'(mq.pop_front());
         end
         if (rdy) begin
            if (bus.way0_wbValid_i && bus.way0_rdWriteEnable_i && bus.way0_rdAddr_i != 0)
               mq.push_back('{a: bus.way0_rdAddr_i, d: bus.way0_rdData_i});
            if (bus.way1_wbValid_i && bus.way1_rdWriteEnable_i && bus.way1_rdAddr_i != 0)
               mq.push_back('{a: bus.way1_rdAddr_i, d: bus.way1_rdData_i});
         end
      end
   end

   task automatic setIn(input logic v0, input logic w0, input logic [4:0] a0, input logic [63:0] d0,
                        input logic v1, input logic w1, input logic [4:0] a1, input logic [63:0] d1,
                        input logic stall);
      bus.way0_wbValid_i       = v0;
      bus.way0_rdWriteEnable_i = w0;
      bus.way0_rdAddr_i        = a0;
      bus.way0_rdData_i        = d0;
      bus.way1_wbValid_i       = v1;
      bus.way1_rdWriteEnable_i = w1;
      bus.way1_rdAddr_i        = a1;
      bus.way1_rdData_i        = d1;
      bus.wbStall_i            = stall;
   endtask

   // Present a pair and hold it until the buffer is ready; acceptance is at the following edge.
   task automatic send(input logic v0, input logic w0, input logic [4:0] a0, input logic [63:0] d0,
                       input logic v1, input logic w1, input logic [4:0] a1, input logic [63:0] d1,
                       input logic stall, input bit randStall);
      bit ok = 0;
      @(posedge clk);
      #1;
      setIn(v0, w0, a0, d0, v1, w1, a1, d1, stall);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.wbReady_o) begin
            ok = 1;
            break;
         end
         @(posedge clk);
         #1;
         bus.wbStall_i = randStall ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (!ok) chk("send_timeout", 64'(0), 64'(1));
   endtask

   task automatic idle(input logic stall);
      @(posedge clk);
      #1;
      setIn(0, 0, 5'd0, 64'd0, 0, 0, 5'd0, 64'd0, stall);
   endtask

   initial begin
      setIn(0, 0, 5'd0, 64'd0, 0, 0, 5'd0, 64'd0, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Idle after reset.
      @(negedge clk);
      chk("rst_pending", 64'(bus.wbPending_o), 64'd0);
      chk("rst_ready",   64'(bus.wbReady_o), 64'd1);
      chk("rst_we0",     64'(bus.way0_rdWriteEnable_o), 64'd0);
      chk("rst_we1",     64'(bus.way1_rdWriteEnable_o), 64'd0);

      // Simple pair.
      send(1, 1, 5'd5, 64'h11, 1, 1, 5'd6, 64'h22, 0, 0);
      idle(0);
      @(negedge clk);
      chk("pair_we0",   64'(bus.way0_rdWriteEnable_o), 64'd1);
      chk("pair_a0",    64'(bus.way0_rdAddr_o), 64'd5);
      chk("pair_d0",    bus.way0_rdData_o, 64'h11);
      chk("pair_we1",   64'(bus.way1_rdWriteEnable_o), 64'd1);
      chk("pair_a1",    64'(bus.way1_rdAddr_o), 64'd6);
      chk("pair_d1",    bus.way1_rdData_o, 64'h22);
      @(negedge clk);
      chk("pair_empty", 64'(bus.wbPending_o), 64'd0);

      // Same destination: younger wins.
      send(1, 1, 5'd7, 64'hAA, 1, 1, 5'd7, 64'hBB, 0, 0);
      idle(0);
      @(negedge clk);
      chk("conf_we0", 64'(bus.way0_rdWriteEnable_o), 64'd0);
      chk("conf_we1", 64'(bus.way1_rdWriteEnable_o), 64'd1);
      chk("conf_a1",  64'(bus.way1_rdAddr_o), 64'd7);
      chk("conf_d1",  bus.way1_rdData_o, 64'hBB);
      @(negedge clk);
      chk("conf_empty", 64'(bus.wbPending_o), 64'd0);

      // Filtered results: x0 target and write-enable low.
      send(1, 1, 5'd0, 64'h33, 1, 0, 5'd3, 64'h44, 0, 0);
      idle(0);
      @(negedge clk);
      chk("filt_pending", 64'(bus.wbPending_o), 64'd0);
      chk("filt_we0",     64'(bus.way0_rdWriteEnable_o), 64'd0);
      chk("filt_we1",     64'(bus.way1_rdWriteEnable_o), 64'd0);

      // Fill under stall, then drain in push order.
      send(1, 1, 5'd1, 64'hA1, 1, 1, 5'd2, 64'hA2, 1, 0);
      send(1, 1, 5'd3, 64'hA3, 1, 1, 5'd4, 64'hA4, 1, 0);
      idle(1);
      @(negedge clk);
      chk("full_pending", 64'(bus.wbPending_o), 64'd4);
      chk("full_ready",   64'(bus.wbReady_o), 64'd0);
      idle(0);
      @(negedge clk);
      chk("drain1_a0", 64'(bus.way0_rdAddr_o), 64'd1);
      chk("drain1_d1", bus.way1_rdData_o, 64'hA2);
      chk("drain1_ready", 64'(bus.wbReady_o), 64'd0);
      @(negedge clk);
      chk("drain2_a0", 64'(bus.way0_rdAddr_o), 64'd3);
      chk("drain2_d1", bus.way1_rdData_o, 64'hA4);
      chk("drain2_ready", 64'(bus.wbReady_o), 64'd1);

      // Asynchronous reset with three entries held.
      send(1, 1, 5'd8, 64'hB8, 1, 1, 5'd9, 64'hB9, 1, 0);
      send(1, 1, 5'd10, 64'hBA, 0, 0, 5'd0, 64'd0, 1, 0);
      idle(1);
      @(negedge clk);
      chk("ar_pending", 64'(bus.wbPending_o), 64'd3);
      @(posedge clk);
      #1 bus.wbStall_i = 1'b0;
      #1;
      chk("ar_we0_pre", 64'(bus.way0_rdWriteEnable_o), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("ar_we0",     64'(bus.way0_rdWriteEnable_o), 64'd0);
      chk("ar_we1",     64'(bus.way1_rdWriteEnable_o), 64'd0);
      chk("ar_pending_0", 64'(bus.wbPending_o), 64'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Alternating one and two results with random stall and colliding addresses.
      for (int i = 0; i < 20; i++) begin
         automatic logic [4:0] ra = 5'($urandom_range(1, 6));
         automatic logic [4:0] rb = 5'($urandom_range(1, 6));
         automatic logic       st = 1'($urandom_range(0, 1));
         if (i % 2 == 0)
            send(1, 1, ra, 64'(100 + 2 * i), 0, 0, 5'd0, 64'd0, st, 1);
         else
            send(1, 1, ra, 64'(100 + 2 * i), 1, 1, rb, 64'(101 + 2 * i), st, 1);
      end
      idle(0);
      repeat (4) @(negedge clk);
      chk("final_pending", 64'(bus.wbPending_o), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
